// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a 16 x 8-bit register file, pointer-based
// auto-increment reads/writes and open-drain SDA drive (no clock stretching).
//
// Ports:
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_scl, i_sda        resolved bus levels, asynchronous to i_clk
//   o_sda_o, o_sda_oe   open-drain SDA: drive value (always 0) and pull-low enable
//   o_wr_stb            one-cycle pulse per bus register write
//   o_wr_addr/o_wr_data index and byte of that write
//   i_dbg_addr          peek index
//   o_dbg_data          combinational reg[i_dbg_addr]; index 0xF reads DEVICE_ID
//   o_busy              high from address match until STOP/START/NACK
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h48,
    parameter logic [7:0] DEVICE_ID   = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_o,
    output logic       o_sda_oe,
    output logic       o_wr_stb,
    output logic [3:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic [3:0] i_dbg_addr,
    output logic [7:0] o_dbg_data,
    output logic       o_busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t      state_q;
    logic [2:0]  scl_q, sda_q;
    logic [7:0]  sh_q;
    logic [3:0]  cnt_q, ptr_q;
    logic        rw_q, ack_on_q;
    logic [7:0]  regs_q [16];
    logic        scl, sda, start, stop, scl_rise, scl_fall;
    logic [3:0]  ptr_nx;
    logic [7:0]  rx_byte, ptr_data, nxt_data;

    // [0],[1] synchronize; [2] holds the previous synchronized level for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], i_scl};
            sda_q <= {sda_q[1:0], i_sda};
        end
    end

    // START/STOP are qualified by the previous SCL level so an SDA change that
    // coincides with an SCL fall is still seen as START/STOP, not as a data edge
    always_comb begin
        scl      = scl_q[1];
        sda      = sda_q[1];
        start    = scl_q[2] & sda_q[2] & ~sda;
        stop     = scl_q[2] & ~sda_q[2] & sda;
        scl_rise = scl & ~scl_q[2];
        scl_fall = ~scl & scl_q[2];
        ptr_nx   = ptr_q + 4'd1;
        rx_byte  = {sh_q[6:0], sda};
        ptr_data = (ptr_q == 4'hF) ? DEVICE_ID : regs_q[ptr_q];
        nxt_data = (ptr_nx == 4'hF) ? DEVICE_ID : regs_q[ptr_nx];
    end

    assign o_sda_o    = 1'b0;
    assign o_dbg_data = (i_dbg_addr == 4'hF) ? DEVICE_ID : regs_q[i_dbg_addr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            sh_q      <= 8'h00;
            cnt_q     <= 4'd0;
            ptr_q     <= 4'd0;
            rw_q      <= 1'b0;
            ack_on_q  <= 1'b0;
            o_sda_oe  <= 1'b0;
            o_busy    <= 1'b0;
            o_wr_stb  <= 1'b0;
            o_wr_addr <= 4'd0;
            o_wr_data <= 8'h00;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else begin
            o_wr_stb <= 1'b0;
            if (start) begin
                state_q  <= ADDR;
                cnt_q    <= 4'd0;
                ack_on_q <= 1'b0;
                o_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else if (stop) begin
                state_q  <= IDLE;
                ack_on_q <= 1'b0;
                o_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        sh_q  <= rx_byte;
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_q <= 4'd0;
                            if (sh_q[6:0] == TARGET_ADDR) begin
                                state_q <= ADDR_ACK;
                                rw_q    <= sda;
                                o_busy  <= 1'b1;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                    PTR: if (scl_rise) begin
                        sh_q  <= rx_byte;
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_q   <= 4'd0;
                            ptr_q   <= rx_byte[3:0];
                            state_q <= PTR_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        sh_q  <= rx_byte;
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_q     <= 4'd0;
                            o_wr_stb  <= 1'b1;
                            o_wr_addr <= ptr_q;
                            o_wr_data <= rx_byte;
                            if (ptr_q != 4'hF) regs_q[ptr_q] <= rx_byte;
                            ptr_q     <= ptr_nx;
                            state_q   <= WDATA_ACK;
                        end
                    end
                    // first fall ends bit 8 (pull SDA low), second fall ends the ACK bit
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        ack_on_q <= ~ack_on_q;
                        o_sda_oe <= ~ack_on_q;
                        if (ack_on_q) begin
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_q  <= RDATA;
                                o_sda_oe <= ~ptr_data[7];
                                sh_q     <= {ptr_data[6:0], 1'b0};
                                cnt_q    <= 4'd1;
                            end else begin
                                state_q <= (state_q == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    // cnt_q counts bits already placed on the bus
                    RDATA: if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            o_sda_oe <= 1'b0;
                            cnt_q    <= 4'd0;
                            state_q  <= RDATA_ACK;
                        end else begin
                            o_sda_oe <= ~sh_q[7];
                            sh_q     <= {sh_q[6:0], 1'b0};
                            cnt_q    <= cnt_q + 4'd1;
                        end
                    end
                    RDATA_ACK: if (scl_rise) begin
                        ptr_q <= ptr_nx;
                        if (!sda) begin
                            sh_q    <= nxt_data;
                            state_q <= RDATA;
                        end else begin
                            state_q <= WAIT;
                            o_busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: open-drain I2C master model driving i2c_target_regs, with
// a write-strobe scoreboard, read-data scoreboard and a table of register peeks.
module tb_i2c_target_regs;
    localparam int T = 80;

    typedef struct {
        int         phase;
        logic [3:0] a;
        logic [7:0] d;
    } peek_t;

    logic       clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_line, sda_o, sda_oe, wr_stb, busy;
    logic [3:0] wr_addr, dbg_addr = 4'd0;
    logic [7:0] wr_data, dbg_data;

    int checks = 0, errors = 0;
    int obs_n = 0, oe_cnt = 0, busy_cnt = 0, rd_i = 0;
    logic [11:0] obs [64];
    logic [11:0] exp_q [$];
    logic [7:0]  rd_q [$];
    peek_t       vec [$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl_m), .i_sda(sda_line),
        .o_sda_o(sda_o), .o_sda_oe(sda_oe), .o_wr_stb(wr_stb),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_dbg_addr(dbg_addr),
        .o_dbg_data(dbg_data), .o_busy(busy)
    );

    always @(negedge clk) begin
        if (wr_stb && obs_n < 64) begin
            obs[obs_n] <= {wr_addr, wr_data};
            obs_n      <= obs_n + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b0; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b1; #T;
    endtask

    task automatic wbit(input logic b);
        sda_m = b; #T;
        scl_m = 1'b1; #(2*T);
        scl_m = 1'b0; #T;
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #T;
        b = sda_line; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic send(input logic [7:0] d, input string nm);
        logic a;
        wbyte(d, a);
        chk(nm, {31'd0, a}, 32'd0);
    endtask

    task automatic rd_chk(input logic nack, input logic [7:0] exp);
        logic [7:0] d;
        logic b;
        rd_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
        chk("rdata", {24'd0, d}, {24'd0, rd_q.pop_front()});
    endtask

    task automatic drain();
        logic [11:0] e;
        while (rd_i < obs_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got 0x%0h expected none", obs[rd_i]);
            end else begin
                e = exp_q.pop_front();
                chk("wr_stb", {20'd0, obs[rd_i]}, {20'd0, e});
            end
            rd_i++;
        end
        chk("wr_missing", exp_q.size(), 32'd0);
    endtask

    task automatic peeks(input int ph);
        foreach (vec[i]) if (vec[i].phase == ph) begin
            dbg_addr = vec[i].a;
            #10;
            chk($sformatf("dbg[%0d]", vec[i].a), {24'd0, dbg_data}, {24'd0, vec[i].d});
        end
    endtask

    initial begin
        int o, b, n;
        logic a;
        vec.push_back('{0, 4'h0, 8'h00});
        vec.push_back('{0, 4'hF, 8'hA5});
        vec.push_back('{0, 4'h3, 8'h00});
        vec.push_back('{1, 4'h3, 8'h11});
        vec.push_back('{1, 4'h4, 8'h22});
        vec.push_back('{1, 4'h5, 8'h5A});
        vec.push_back('{2, 4'hE, 8'h55});
        vec.push_back('{2, 4'hF, 8'hA5});
        vec.push_back('{2, 4'h0, 8'h77});
        vec.push_back('{3, 4'h6, 8'h00});
        vec.push_back('{4, 4'h6, 8'h3C});
        for (int i = 0; i < 16; i++) vec.push_back('{5, 4'(i), (i == 15) ? 8'hA5 : 8'h00});

        #20;
        chk("rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_stb", {31'd0, wr_stb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("sda_o", {31'd0, sda_o}, 32'd0);
        peeks(0);
        rst_n = 1'b1;
        #100;

        i2c_start(); send(8'h90, "ack_addr"); send(8'h05, "ack_ptr");
        exp_q.push_back({4'h5, 8'h5A}); send(8'h5A, "ack_data");
        i2c_stop(); drain();

        i2c_start(); send(8'h90, "ack_addr");
        chk("busy_match", {31'd0, busy}, 32'd1);
        send(8'h03, "ack_ptr");
        exp_q.push_back({4'h3, 8'h11}); send(8'h11, "ack_data");
        exp_q.push_back({4'h4, 8'h22}); send(8'h22, "ack_data");
        i2c_stop();
        chk("busy_stop", {31'd0, busy}, 32'd0);
        drain(); peeks(1);

        i2c_start(); send(8'h90, "ack_addr"); send(8'h03, "ack_ptr");
        i2c_start(); send(8'h91, "ack_raddr");
        rd_chk(1'b0, 8'h11); rd_chk(1'b1, 8'h22);
        chk("oe_after_nack", {31'd0, sda_oe}, 32'd0);
        chk("busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop();
        i2c_start(); send(8'h91, "ack_raddr"); rd_chk(1'b1, 8'h5A); i2c_stop();

        o = oe_cnt; b = busy_cnt; n = obs_n;
        i2c_start(); wbyte(8'h92, a);
        chk("mismatch_nack", {31'd0, a}, 32'd1);
        i2c_stop();
        chk("mismatch_oe", oe_cnt, o);
        chk("mismatch_busy", busy_cnt, b);
        chk("mismatch_stb", obs_n, n);

        i2c_start(); send(8'h90, "ack_addr"); send(8'h0E, "ack_ptr");
        exp_q.push_back({4'hE, 8'h55}); send(8'h55, "ack_data");
        exp_q.push_back({4'hF, 8'h66}); send(8'h66, "ack_data");
        exp_q.push_back({4'h0, 8'h77}); send(8'h77, "ack_data");
        i2c_stop(); drain(); peeks(2);
        i2c_start(); send(8'h90, "ack_addr"); send(8'h0F, "ack_ptr");
        i2c_start(); send(8'h91, "ack_raddr");
        rd_chk(1'b0, 8'hA5); rd_chk(1'b1, 8'h77);
        i2c_stop();

        i2c_start(); send(8'h90, "ack_addr"); send(8'h06, "ack_ptr");
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop();
        chk("midstop_oe", {31'd0, sda_oe}, 32'd0);
        chk("midstop_busy", {31'd0, busy}, 32'd0);
        drain(); peeks(3);
        i2c_start(); send(8'h90, "ack_addr"); send(8'h06, "ack_ptr");
        exp_q.push_back({4'h6, 8'h3C}); send(8'h3C, "ack_data");
        i2c_stop(); drain(); peeks(4);

        i2c_start(); send(8'h90, "ack_addr"); send(8'h03, "ack_ptr");
        i2c_start(); send(8'h91, "ack_raddr");
        chk("rd_drive0", {31'd0, sda_oe}, 32'd1);
        #3 rst_n = 1'b0;
        #1 chk("async_release", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy2", {31'd0, busy}, 32'd0);
        scl_m = 1'b1; sda_m = 1'b1;
        #6;
        peeks(5);
        rst_n = 1'b1;
        #100;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Synthesizable I2C target (slave) with a 16-entry 8-bit register file, built as the responding end of the SoC's I2C masters (i2c_0 and the on-board sensor buses). The bench attaches it to a master's open-drain SCL/SDA pair to model a sensor. It can also be instantiated in the FPGA image as a loopback target. It decodes START/STOP, matches a 7-bit address, ACKs, supports pointer-based auto-increment reads and writes, and drives SDA open-drain only. It does not stretch SCL.

## Interface
Parameters:
- TARGET_ADDR, 7'h48, 7-bit bus address this target responds to
- DEVICE_ID, 8'hA5, value returned by read-only register 0x0F

Ports:
- i_clk  in  1  system clock; all logic on the rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_scl  in  1  resolved SCL line level, asynchronous to i_clk
- i_sda  in  1  resolved SDA line level, asynchronous to i_clk
- o_sda_o  out  1  SDA drive value, constant 0
- o_sda_oe  out  1  1 = pull SDA low; 0 = release
- o_wr_stb  out  1  one-cycle pulse when the bus writes a register
- o_wr_addr  out  4  register index written, valid with o_wr_stb
- o_wr_data  out  8  byte written, valid with o_wr_stb
- i_dbg_addr  in  4  bench peek index
- o_dbg_data  out  8  combinational read of reg[i_dbg_addr]; 0x0F returns DEVICE_ID
- o_busy  out  1  high from address match until the next STOP, START, NACK, or address mismatch

## Operation
- **Input conditioning:** i_scl and i_sda pass through 2-flop synchronizers, then a history flop for edge detection.
- **Bus events:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise: sample point.
  - SCL fall: drive-change point.
- **State machine:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- **IDLE:** wait for START.
- **START in any state:** go to ADDR with bit counter = 0 and o_sda_oe = 0. This covers repeated START.
- **STOP in any state:** go to IDLE, o_sda_oe = 0, o_busy = 0. Pointer is retained.
- **ADDR:** shift 8 bits MSB first on SCL rises.
  - If bits[7:1] == TARGET_ADDR: go to ADDR_ACK and set o_busy.
  - Otherwise go to WAIT and never drive SDA.
- **ADDR_ACK:** on the SCL fall after bit 8, assert o_sda_oe. On the next SCL fall, release it.
  - R/W = 0: go to PTR.
  - R/W = 1: go to RDATA and load the shift register with reg[ptr].
- **PTR:** receive a byte; ptr <= byte[3:0] (bits 7:4 ignored). ACK, then go to WDATA.
- **WDATA:** receive a byte; ACK. At the ACK bit, pulse o_wr_stb with o_wr_addr = ptr.
  - Write reg[ptr] unless ptr == 0x0F; writes to 0x0F are ACKed and discarded, and o_wr_stb still pulses.
  - ptr <= ptr + 1 mod 16 (0x0F wraps to 0x00). Return to WDATA.
- **RDATA:** drive o_sda_oe = ~bit on each SCL fall, MSB first. The first bit is driven on the SCL fall that ends ADDR_ACK. After 8 bits, release SDA and go to RDATA_ACK.
- **RDATA_ACK:** sample SDA on SCL rise; ptr <= ptr + 1 mod 16.
  - SDA = 0 (ACK): reload from the new ptr and continue RDATA.
  - SDA = 1 (NACK): go to WAIT and release SDA.
- **WAIT:** ignore everything until START or STOP.
- **Register reset values:** all registers 0x00; 0x0F is read-only and reads DEVICE_ID.

## Timing
- **Reset values:** all outputs 0, state IDLE, ptr 0, synchronizers 1 (idle bus).
- **Event detect latency:** an event is detected 3 i_clk cycles after the pin changes.
- **SDA drive latency:** o_sda_oe updates on the cycle after a detected SCL fall, i.e. 4 cycles after the pin fall.
- **o_wr_stb:** single-cycle, asserted the cycle after the 8th data-bit SCL rise is detected. The register file updates in the same cycle, so o_dbg_data reflects the new value from the next cycle.
- **Clock ratio requirement:** SCL high and low phases each ≥ 8 i_clk periods. SDA setup/hold around SCL edges ≥ 4 i_clk periods.
- **Simultaneous SCL and SDA change:** START/STOP detection takes priority over the SCL edge.
- **Mid-transaction reset:** SDA is released immediately (asynchronously) and the machine returns to IDLE.

## Test plan
- **Write two bytes:** START, 0x90, 0x03, 0x11, 0x22, STOP.
  - All four bytes ACKed.
  - o_wr_stb pulses twice: (3, 0x11) then (4, 0x22).
  - dbg reads reg3 = 0x11, reg4 = 0x22.
- **Combined read:** START, 0x90, 0x03, repeated START, 0x91, read 2 bytes (ACK, then NACK), STOP.
  - Returns 0x11, 0x22.
  - SDA is released after the NACK.
  - Final ptr = 5.
- **Address mismatch:** START, 0x92, STOP.
  - Address byte is NACKed (SDA never low).
  - o_busy stays 0; no o_wr_stb.
- **Wrap and ID register:** write ptr 0x0E, data 0x55, 0x66, 0x77.
  - reg14 = 0x55.
  - The 0x0F write is ignored; dbg 0x0F = 0xA5.
  - reg0 = 0x77.
  - Then read from ptr 0x0F returns 0xA5, 0x77.
- **STOP mid-byte:** STOP issued after 4 data bits.
  - State returns to IDLE, no write occurs, SDA is released.
  - The next transaction works normally.
- **Reset mid-read:** assert i_rst_n low while the target is driving a 0 bit.
  - o_sda_oe drops to 0 without waiting for a clock edge.
  - All registers read 0x00 (0x0F still reads 0xA5).
